// File: rtl/cnn_dot_engine.sv
// -----------------------------------------------------------------------------
// cnn_dot_engine
//
// Purpose:
//   First compute stage of the card-classifier datapath. On start it reads
//   N_TAPS signed weights and N_TAPS signed pixels from the parameter/image
//   memory through a 1-cycle-latency read port. It accumulates their products
//   in a wrapping ACC_W-bit signed accumulator. It then scales the sum by an
//   arithmetic right shift of SHIFT bits, saturates it to 8 bits and presents
//   it on a valid/ready output.
//
// Build option:
//   CNN_RELU_EN  when defined, negative saturated results are clamped to 0
//                (result range 0..127). Timing and handshake are unchanged.
//
// Ports:
//   clk           in   1       single clock, rising edge
//   reset         in   1       synchronous, active-high
//   start         in   1       request one dot product (honoured only in IDLE)
//   busy          out  1       high in every state except IDLE
//   mem_rd        out  1       memory read strobe
//   mem_addr      out  ADDR_W  read address (held when mem_rd=0)
//   mem_rdata     in   8       signed read data, valid the cycle after mem_rd
//   result        out  8       signed scaled/saturated dot product
//   result_valid  out  1       result available
//   result_ready  in   1       consumer accepts result when valid && ready
// -----------------------------------------------------------------------------
module cnn_dot_engine #(
  parameter int N_TAPS = 9,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 20,
  parameter int W_BASE = 0,
  parameter int X_BASE = 16,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(128));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_W = 3'd1,
    RD_X = 3'd2,
    MAC  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [IDX_W-1:0]         r_idx;
  logic signed [7:0]        r_w;
  logic signed [ACC_W-1:0]  r_acc_p0;
  logic signed [7:0]        r_res_p1;
  logic                     r_vld_p1;
  logic [ADDR_W-1:0]        r_addr_hold;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_rd;
  logic signed [15:0]       w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;

  // Scale, saturate and (optionally) rectify the accumulator.
  function automatic logic signed [7:0] scale_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] scaled;
    logic signed [7:0]       sat;
    scaled = acc >>> SHIFT;
    if (scaled > SAT_MAX) begin
      sat = 8'h7F;
    end else if (scaled < SAT_MIN) begin
      sat = 8'h80;
    end else begin
      sat = scaled[7:0];
    end
`ifdef CNN_RELU_EN
    if (sat[7]) begin
      sat = 8'h00;
    end
`else
    sat = sat;
`endif
    return sat;
  endfunction

  // Signed 8x8 -> 16 product, sign-extended to the accumulator width.
  assign w_prod     = r_w * $signed(mem_rdata);
  assign w_prod_ext = $signed({{(ACC_W-16){w_prod[15]}}, w_prod});

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RD_W;
      RD_W:    w_next = RD_X;
      RD_X:    w_next = MAC;
      MAC:     w_next = (r_idx == LAST_IDX) ? OUT : RD_W;
      OUT:     if (r_vld_p1 && result_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Memory read port: strobe only in the two read states; the address
  // otherwise holds whatever was last presented.
  always_comb begin
    w_rd   = 1'b0;
    w_addr = r_addr_hold;
    case (r_state)
      RD_W: begin
        w_rd   = 1'b1;
        w_addr = ADDR_W'(W_BASE) + ADDR_W'(r_idx);
      end
      RD_X: begin
        w_rd   = 1'b1;
        w_addr = ADDR_W'(X_BASE) + ADDR_W'(r_idx);
      end
      default: begin
        w_rd   = 1'b0;
        w_addr = r_addr_hold;
      end
    endcase
  end

  assign mem_rd       = w_rd;
  assign mem_addr     = w_addr;
  assign busy         = (r_state != IDLE);
  assign result       = r_res_p1;
  assign result_valid = r_vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_w         <= '0;
      r_acc_p0    <= '0;
      r_res_p1    <= '0;
      r_vld_p1    <= 1'b0;
      r_addr_hold <= '0;
    end else begin
      r_state     <= w_next;
      r_addr_hold <= w_addr;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc_p0 <= '0;
            r_idx    <= '0;
          end
        end
        RD_X: begin
          r_w <= $signed(mem_rdata);
        end
        // p0: accumulate one tap
        MAC: begin
          r_acc_p0 <= r_acc_p0 + w_prod_ext;
          if (r_idx != LAST_IDX) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        // p1: the scaled result is registered one cycle after the final
        // accumulate, then held until the consumer takes it.
        OUT: begin
          if (!r_vld_p1) begin
            r_res_p1 <= scale_sat(r_acc_p0);
            r_vld_p1 <= 1'b1;
          end else if (result_ready) begin
            r_vld_p1 <= 1'b0;
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

endmodule
